// File: rtl/line_buffer_window_if.sv
// Pixel write/read bus between a line buffer and its producer/consumer.
interface line_buffer_window_if #(
    parameter int IMAGE_WIDTH = 512,
    parameter int PIXEL_SIZE  = 32,
    parameter int TAPS        = 3
);
    logic [PIXEL_SIZE-1:0]             i_data;
    logic                              i_data_valid;
    logic                              i_data_rd;
    logic [PIXEL_SIZE*TAPS-1:0]        o_data;
    logic                              o_data_valid;
    logic                              o_line_ready;
    logic [$clog2(IMAGE_WIDTH+1)-1:0]  o_count;
    logic                              o_overflow;
    logic                              o_underflow;

    // Producer/consumer side
    modport master (
        output i_data, i_data_valid, i_data_rd,
        input  o_data, o_data_valid, o_line_ready, o_count, o_overflow, o_underflow
    );

    // Line buffer side
    modport slave (
        input  i_data, i_data_valid, i_data_rd,
        output o_data, o_data_valid, o_line_ready, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/line_buffer_window.sv
// Single-line pixel buffer presenting TAPS adjacent pixels per read, with
// fill/read control, occupancy count and sticky overflow/underflow flags.
module line_buffer_window #(
    parameter int IMAGE_WIDTH = 512,
    parameter int PIXEL_SIZE  = 32,
    parameter int TAPS        = 3,
    parameter int PAD_MODE    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    line_buffer_window_if.slave  bus
);
    localparam int CW = $clog2(IMAGE_WIDTH + 1);
    localparam int PW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

    typedef enum logic {FILL = 1'b0, READ = 1'b1} state_t;

    logic [PIXEL_SIZE-1:0]            r_mem [IMAGE_WIDTH];
    logic [PW-1:0]                    r_wr_ptr;
    logic [PW-1:0]                    r_rd_ptr;
    logic [CW-1:0]                    r_count;
    state_t                           r_state;
    logic                             r_line_ready;
    logic [PIXEL_SIZE*TAPS-1:0]       r_data;
    logic                             r_data_valid;
    logic                             r_overflow;
    logic                             r_underflow;

    logic                             w_rd_acc;
    logic                             w_wr_acc;
    logic [CW-1:0]                    w_count_nxt;
    logic [TAPS-1:0][PIXEL_SIZE-1:0]  w_win;

    // Accept decisions: a full buffer still takes a write when a read frees a slot
    assign w_rd_acc = bus.i_data_rd && (r_state == READ);
    assign w_wr_acc = bus.i_data_valid && ((r_count < CW'(IMAGE_WIDTH)) || w_rd_acc);

    // Occupancy after this cycle's accepted write/read
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc)
            w_count_nxt = r_count + 1'b1;
        else if (!w_wr_acc && w_rd_acc)
            w_count_nxt = r_count - 1'b1;
    end

    // Tap address generation; tap 0 lands in the MSB slice of the window
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic [PW:0]   w_sum;
        logic [PW-1:0] w_addr;

        // Sum held one bit wider so addresses past the line end are seen, not truncated
        always_comb begin
            w_sum = {1'b0, r_rd_ptr} + (PW+1)'(k);
            if (w_sum <= (PW+1)'(IMAGE_WIDTH - 1))
                w_addr = w_sum[PW-1:0];
            else if (PAD_MODE == 0)
                w_addr = PW'(w_sum - (PW+1)'(IMAGE_WIDTH));
            else
                w_addr = PW'(IMAGE_WIDTH - 1);
        end

        assign w_win[TAPS-1-k] = r_mem[w_addr];
    end

    // Pixel storage; not reset. Nonblocking write gives read-before-write on collision
    always_ff @(posedge clk) begin
        if (w_wr_acc && !reset)
            r_mem[r_wr_ptr] <= bus.i_data;
    end

    // Pointers, occupancy, fill/read FSM, output window and error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= FILL;
            r_line_ready <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            r_data_valid <= w_rd_acc;

            if (w_wr_acc)
                r_wr_ptr <= (r_wr_ptr == PW'(IMAGE_WIDTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            else if (bus.i_data_valid)
                r_overflow <= 1'b1;

            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == PW'(IMAGE_WIDTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                r_data   <= w_win;
            end else if (bus.i_data_rd) begin
                r_underflow <= 1'b1;
            end

            case (r_state)
                FILL: begin
                    if (w_count_nxt == CW'(IMAGE_WIDTH)) begin
                        r_state      <= READ;
                        r_line_ready <= 1'b1;
                    end
                end
                READ: begin
                    // Drop back only at line end and only if streaming did not keep it full
                    if (w_rd_acc && (r_rd_ptr == PW'(IMAGE_WIDTH - 1)) &&
                        (w_count_nxt < CW'(IMAGE_WIDTH))) begin
                        r_state      <= FILL;
                        r_line_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= FILL;
                    r_line_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data       = r_data;
    assign bus.o_data_valid = r_data_valid;
    assign bus.o_line_ready = r_line_ready;
    assign bus.o_count      = r_count;
    assign bus.o_overflow   = r_overflow;
    assign bus.o_underflow  = r_underflow;
endmodule

// File: tb/tb_line_buffer_window.sv
// Directed bench: two instances (wrap and replicate padding) driven by the same stimulus.
module tb_line_buffer_window;
    localparam int W  = 8;
    localparam int PS = 32;
    localparam int T  = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    line_buffer_window_if #(.IMAGE_WIDTH(W), .PIXEL_SIZE(PS), .TAPS(T)) ifa ();
    line_buffer_window_if #(.IMAGE_WIDTH(W), .PIXEL_SIZE(PS), .TAPS(T)) ifb ();

    assign ifb.i_data       = ifa.i_data;
    assign ifb.i_data_valid = ifa.i_data_valid;
    assign ifb.i_data_rd    = ifa.i_data_rd;

    line_buffer_window #(.IMAGE_WIDTH(W), .PIXEL_SIZE(PS), .TAPS(T), .PAD_MODE(0)) u_pad0 (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    line_buffer_window #(.IMAGE_WIDTH(W), .PIXEL_SIZE(PS), .TAPS(T), .PAD_MODE(1)) u_pad1 (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    always #5 clk = ~clk;

    function automatic logic [95:0] win(input int a, input int b, input int c);
        return {32'(a), 32'(b), 32'(c)};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control/status of both instances against one expectation
    task automatic chk_stat(input string tag, input int cnt, input logic rdy,
                            input logic vld, input logic ovf, input logic udf);
        chk({tag, " a.count"}, 96'(ifa.o_count), 96'(cnt));
        chk({tag, " b.count"}, 96'(ifb.o_count), 96'(cnt));
        chk({tag, " a.ready"}, 96'(ifa.o_line_ready), 96'(rdy));
        chk({tag, " b.ready"}, 96'(ifb.o_line_ready), 96'(rdy));
        chk({tag, " a.valid"}, 96'(ifa.o_data_valid), 96'(vld));
        chk({tag, " b.valid"}, 96'(ifb.o_data_valid), 96'(vld));
        chk({tag, " a.ovf"},   96'(ifa.o_overflow), 96'(ovf));
        chk({tag, " b.ovf"},   96'(ifb.o_overflow), 96'(ovf));
        chk({tag, " a.udf"},   96'(ifa.o_underflow), 96'(udf));
        chk({tag, " b.udf"},   96'(ifb.o_underflow), 96'(udf));
    endtask

    logic [95:0] exp_a [8];
    logic [95:0] exp_b [8];

    initial begin
        reset            = 1'b1;
        ifa.i_data       = '0;
        ifa.i_data_valid = 1'b0;
        ifa.i_data_rd    = 1'b0;
        tick();
        tick();
        chk_stat("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset a.data", ifa.o_data, '0);
        chk("reset b.data", ifb.o_data, '0);
        reset = 1'b0;

        // 1: fill the line with 1..8
        for (int i = 1; i <= W; i++) begin
            ifa.i_data       = 32'(i);
            ifa.i_data_valid = 1'b1;
            tick();
            chk_stat($sformatf("fill%0d", i), i, (i == W), 1'b0, 1'b0, 1'b0);
        end
        ifa.i_data_valid = 1'b0;

        // 2/3: drain the line, wrap vs replicate at the end
        exp_a = '{win(1,2,3), win(2,3,4), win(3,4,5), win(4,5,6),
                  win(5,6,7), win(6,7,8), win(7,8,1), win(8,1,2)};
        exp_b = '{win(1,2,3), win(2,3,4), win(3,4,5), win(4,5,6),
                  win(5,6,7), win(6,7,8), win(7,8,8), win(8,8,8)};
        ifa.i_data_rd = 1'b1;
        for (int j = 0; j < W; j++) begin
            tick();
            chk_stat($sformatf("drain%0d", j), W-1-j, (j != W-1), 1'b1, 1'b0, 1'b0);
            chk($sformatf("drain%0d a.data", j), ifa.o_data, exp_a[j]);
            chk($sformatf("drain%0d b.data", j), ifb.o_data, exp_b[j]);
        end
        ifa.i_data_rd = 1'b0;
        tick();
        chk_stat("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle a.hold", ifa.o_data, win(8,1,2));
        chk("idle b.hold", ifb.o_data, win(8,8,8));

        // 4: read during fill is rejected
        for (int i = 11; i <= 13; i++) begin
            ifa.i_data       = 32'(i);
            ifa.i_data_valid = 1'b1;
            tick();
        end
        ifa.i_data_valid = 1'b0;
        ifa.i_data_rd    = 1'b1;
        tick();
        chk_stat("underflow", 3, 1'b0, 1'b0, 1'b0, 1'b1);
        ifa.i_data_rd    = 1'b0;
        for (int i = 14; i <= 18; i++) begin
            ifa.i_data       = 32'(i);
            ifa.i_data_valid = 1'b1;
            tick();
        end
        ifa.i_data_valid = 1'b0;
        chk_stat("refill", 8, 1'b1, 1'b0, 1'b0, 1'b1);
        ifa.i_data_rd = 1'b1;
        tick();
        chk_stat("rdptr_kept", 7, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("rdptr_kept a.data", ifa.o_data, win(11,12,13));
        chk("rdptr_kept b.data", ifb.o_data, win(11,12,13));
        ifa.i_data_rd = 1'b0;

        // 5: top up, then a dropped write while full
        ifa.i_data       = 32'd19;
        ifa.i_data_valid = 1'b1;
        tick();
        chk_stat("topup", 8, 1'b1, 1'b0, 1'b0, 1'b1);
        ifa.i_data = 32'd20;
        tick();
        chk_stat("overflow", 8, 1'b1, 1'b0, 1'b1, 1'b1);

        // 5: stream one write + one read per cycle while full (read-before-write)
        exp_a = '{win(12,13,14), win(13,14,15), win(14,15,16), win(15,16,17),
                  win(16,17,18), win(17,18,19), win(18,19,21), win(19,21,22)};
        exp_b = '{win(12,13,14), win(13,14,15), win(14,15,16), win(15,16,17),
                  win(16,17,18), win(17,18,18), win(18,18,18), win(19,21,22)};
        ifa.i_data_rd = 1'b1;
        for (int t = 0; t < W; t++) begin
            ifa.i_data = 32'(21 + t);
            tick();
            chk_stat($sformatf("stream%0d", t), 8, 1'b1, 1'b1, 1'b1, 1'b1);
            chk($sformatf("stream%0d a.data", t), ifa.o_data, exp_a[t]);
            chk($sformatf("stream%0d b.data", t), ifb.o_data, exp_b[t]);
        end

        // 6: reset in the middle of a read stream
        ifa.i_data_valid = 1'b0;
        tick();
        tick();
        chk_stat("pre_reset", 6, 1'b1, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        chk_stat("mid_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_reset a.data", ifa.o_data, '0);
        chk("mid_reset b.data", ifb.o_data, '0);
        reset         = 1'b0;
        ifa.i_data_rd = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
